// File: rtl/seq_divider_if.sv
// Operand/result bundle between the execute stage and seq_divider.
// Handshake: the master raises start with op/dividend/divisor valid; the divider
// accepts it on any rising edge where it is idle, signals busy until the result
// has been delivered, and pulses done for exactly one cycle when result is valid.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, dividend, divisor,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor,
        output busy, done, result
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-and-subtract divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_divider_if.slave       div_if,
    output logic [1:0]         o_dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_b_mag;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CW-1:0]    r_cnt;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_quo_fin;
    logic [WIDTH-1:0] w_rem_fin;

    // Unsigned ops never treat the top bit as a sign.
    assign w_a_neg  = ~r_op[0] & r_a[WIDTH-1];
    assign w_b_neg  = ~r_op[0] & r_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~r_a + 1'b1) : r_a;
    assign w_b_mag  = w_b_neg ? (~r_b + 1'b1) : r_b;
    assign w_b_zero = (r_b == '0);

    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_b_mag};

    // Divide by zero overrides the signed fix-up with the ISA-defined values.
    always_comb begin
        w_quo_fin = r_qsign ? (~r_quo + 1'b1) : r_quo;
        w_rem_fin = r_rsign ? (~r_rem + 1'b1) : r_rem;
        if (r_dz) begin
            w_quo_fin = '1;
            w_rem_fin = r_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_b_mag  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (div_if.start) begin
                        r_busy  <= 1'b1;
                        r_op    <= div_if.op;
                        r_a     <= div_if.dividend;
                        r_b     <= div_if.divisor;
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_b_mag <= w_b_mag;
                    r_quo   <= w_a_mag;
                    r_rem   <= '0;
                    r_qsign <= w_a_neg ^ w_b_neg;
                    r_rsign <= w_a_neg;
                    r_dz    <= w_b_zero;
                    r_cnt   <= CW'(WIDTH);
`ifdef DIV_ZERO_FAST_EN
                    r_state <= w_b_zero ? ST_FIN : ST_CALC;
`else
                    r_state <= ST_CALC;
`endif
                end
                ST_CALC: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // busy stays high through the done cycle and drops in IDLE.
                    r_done   <= 1'b1;
                    r_result <= r_op[1] ? w_rem_fin : w_quo_fin;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign div_if.busy   = r_busy;
    assign div_if.done   = r_done;
    assign div_if.result = r_result;
    assign o_dbg_state   = r_state;
endmodule
